// File: rtl/pleiads_input_ctrl.sv
// pleiads_input_ctrl
//
// Input-conditioning stage between hps_io and the phoenix core button inputs.
// PS/2 key events arrive toggle-strobed. They are decoded into held-key state
// and merged with both joysticks. Left and right pressed together resolve to
// neutral. A coin request becomes one fixed-length pulse per press. Fire can
// be modulated by autofire. Every output is registered.
//
// Ports:
//   clk              system clock (clk_sys domain)
//   reset_n          synchronous active-low reset
//   ps2_key[10:0]    [10]=event toggle, [9]=pressed, [8]=extended, [7:0]=scan code
//   joystick_0[15:0] player 1 joystick bits
//   joystick_1[15:0] player 2 joystick bits
//   autofire_en      level, enables autofire on btn_fire
//   btn_coin         stretched coin pulse
//   btn_player_start [0]=start 1P, [1]=start 2P
//   btn_left         move left
//   btn_right        move right
//   btn_barrier      barrier
//   btn_fire         fire (autofire-modulated)

module pleiads_input_ctrl #(
  parameter int COIN_PULSE_CYCLES = 1100000,
  parameter int COIN_GAP_CYCLES   = 1100000,
  parameter int AUTOFIRE_PERIOD   = 733333
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        autofire_en,
  output logic        btn_coin,
  output logic [1:0]  btn_player_start,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_barrier,
  output logic        btn_fire
);

  localparam int COIN_MAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                            COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
  localparam int COIN_W   = $clog2(COIN_MAX + 1);
  localparam int AF_W     = $clog2(AUTOFIRE_PERIOD + 1);

  localparam logic [COIN_W-1:0] PULSE_LOAD = COIN_W'(COIN_PULSE_CYCLES - 1);
  localparam logic [COIN_W-1:0] GAP_LOAD   = COIN_W'(COIN_GAP_CYCLES - 1);
  localparam logic [COIN_W-1:0] COIN_ONE   = COIN_W'(1);
  localparam logic [AF_W-1:0]   AF_LAST    = AF_W'(AUTOFIRE_PERIOD - 1);
  localparam logic [AF_W-1:0]   AF_ONE     = AF_W'(1);

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_GAP,
    COIN_WAIT_REL
  } coin_state_t;

  // ---------------------------------------------------------------------------
  // PS/2 event detection and scan-code matching
  // ---------------------------------------------------------------------------
  logic       prev_toggle;
  logic       ps2_event;
  logic       pressed;
  logic [8:0] code9;
  logic [7:0] code8;

  assign ps2_event = ps2_key[10] ^ prev_toggle;
  assign pressed   = ps2_key[9];
  assign code9     = ps2_key[8:0];
  assign code8     = ps2_key[7:0];

  // Codes written "X.." ignore the extended bit. All other codes must match
  // all nine bits, so extended variants of them are treated as unknown keys.
  logic hit_up, hit_down, hit_left, hit_right, hit_fire, hit_barrier;
  logic hit_start1_a, hit_start1_b, hit_start2_a, hit_start2_b;
  logic hit_coin_a, hit_coin_b;
  logic hit_left2, hit_right2, hit_fire2, hit_barrier2;

  assign hit_up       = (code8 == 8'h75);
  assign hit_down     = (code8 == 8'h72);
  assign hit_left     = (code8 == 8'h6B);
  assign hit_right    = (code8 == 8'h74);
  assign hit_fire     = (code9 == 9'h029);
  assign hit_barrier  = (code8 == 8'h14);
  assign hit_start1_a = (code9 == 9'h005);
  assign hit_start1_b = (code9 == 9'h016);
  assign hit_start2_a = (code9 == 9'h006);
  assign hit_start2_b = (code9 == 9'h01E);
  assign hit_coin_a   = (code9 == 9'h02E);
  assign hit_coin_b   = (code9 == 9'h036);
  assign hit_left2    = (code9 == 9'h023);
  assign hit_right2   = (code9 == 9'h034);
  assign hit_fire2    = (code9 == 9'h01C);
  assign hit_barrier2 = (code9 == 9'h01B);

  // Held-key state. Keys that share a function keep separate registers. That
  // way, releasing one of them does not cancel the other while it is held.
  logic key_up, key_down, key_left, key_right, key_fire, key_barrier;
  logic key_start1_a, key_start1_b, key_start2_a, key_start2_b;
  logic key_coin_a, key_coin_b;
  logic key_left2, key_right2, key_fire2, key_barrier2;

  // Key-state registers. prev_toggle is loaded from the live toggle during
  // reset. This ensures that a toggle flip seen while in reset does not
  // register as an event on the first cycle afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_toggle  <= ps2_key[10];
      key_up       <= 1'b0;
      key_down     <= 1'b0;
      key_left     <= 1'b0;
      key_right    <= 1'b0;
      key_fire     <= 1'b0;
      key_barrier  <= 1'b0;
      key_start1_a <= 1'b0;
      key_start1_b <= 1'b0;
      key_start2_a <= 1'b0;
      key_start2_b <= 1'b0;
      key_coin_a   <= 1'b0;
      key_coin_b   <= 1'b0;
      key_left2    <= 1'b0;
      key_right2   <= 1'b0;
      key_fire2    <= 1'b0;
      key_barrier2 <= 1'b0;
    end else begin
      prev_toggle <= ps2_key[10];
      if (ps2_event) begin
        if (hit_up)       key_up       <= pressed;
        if (hit_down)     key_down     <= pressed;
        if (hit_left)     key_left     <= pressed;
        if (hit_right)    key_right    <= pressed;
        if (hit_fire)     key_fire     <= pressed;
        if (hit_barrier)  key_barrier  <= pressed;
        if (hit_start1_a) key_start1_a <= pressed;
        if (hit_start1_b) key_start1_b <= pressed;
        if (hit_start2_a) key_start2_a <= pressed;
        if (hit_start2_b) key_start2_b <= pressed;
        if (hit_coin_a)   key_coin_a   <= pressed;
        if (hit_coin_b)   key_coin_b   <= pressed;
        if (hit_left2)    key_left2    <= pressed;
        if (hit_right2)   key_right2   <= pressed;
        if (hit_fire2)    key_fire2    <= pressed;
        if (hit_barrier2) key_barrier2 <= pressed;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Raw merge of keyboard and both joysticks
  // ---------------------------------------------------------------------------
  logic [15:0] joy;
  logic raw_right, raw_left, raw_fire, raw_barrier, raw_start1, raw_start2, raw_coin;

  assign joy         = joystick_0 | joystick_1;
  assign raw_right   = key_right   | key_right2   | joy[0];
  assign raw_left    = key_left    | key_left2    | joy[1];
  assign raw_fire    = key_fire    | key_fire2    | joy[4];
  assign raw_barrier = key_barrier | key_barrier2 | joy[5];
  assign raw_start1  = key_start1_a | key_start1_b | joy[6];
  assign raw_start2  = key_start2_a | key_start2_b | joy[7];
  assign raw_coin    = key_coin_a   | key_coin_b   | joy[8];

  // Up/down keys and the spare joystick bits are decoded but have no button
  // on this board. They are collected here so that their omission is explicit.
  logic unused_bits;
  assign unused_bits = ^{key_up, key_down, joy[15:9], joy[3:2]};

  // Directional and start outputs. Left+right together becomes neutral rather
  // than letting either direction win.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_left         <= 1'b0;
      btn_right        <= 1'b0;
      btn_barrier      <= 1'b0;
      btn_player_start <= 2'b00;
    end else begin
      btn_left         <= raw_left & ~raw_right;
      btn_right        <= raw_right & ~raw_left;
      btn_barrier      <= raw_barrier;
      btn_player_start <= {raw_start2, raw_start1};
    end
  end

  // ---------------------------------------------------------------------------
  // Coin stretcher
  // ---------------------------------------------------------------------------
  coin_state_t       coin_state, coin_next;
  logic [COIN_W-1:0] coin_cnt, coin_cnt_next;

  // Coin state register. btn_coin is registered from the next state, so it
  // is exactly "state is PULSE" without a decode glitch. Reset lands in
  // WAIT_REL, so a coin held through reset must be released before it counts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      coin_state <= COIN_WAIT_REL;
      coin_cnt   <= '0;
      btn_coin   <= 1'b0;
    end else begin
      coin_state <= coin_next;
      coin_cnt   <= coin_cnt_next;
      btn_coin   <= (coin_next == COIN_PULSE);
    end
  end

  // Coin next-state logic. The pulse and gap lengths are fixed by the down
  // counter alone. Raw coin is only consulted when leaving IDLE, GAP and
  // WAIT_REL, so releasing early cannot shorten a pulse.
  always_comb begin
    coin_next     = coin_state;
    coin_cnt_next = coin_cnt;
    case (coin_state)
      COIN_IDLE: begin
        if (raw_coin) begin
          coin_next     = COIN_PULSE;
          coin_cnt_next = PULSE_LOAD;
        end
      end
      COIN_PULSE: begin
        if (coin_cnt == '0) begin
          coin_next     = COIN_GAP;
          coin_cnt_next = GAP_LOAD;
        end else begin
          coin_cnt_next = coin_cnt - COIN_ONE;
        end
      end
      COIN_GAP: begin
        if (coin_cnt == '0) begin
          coin_next = raw_coin ? COIN_WAIT_REL : COIN_IDLE;
        end else begin
          coin_cnt_next = coin_cnt - COIN_ONE;
        end
      end
      COIN_WAIT_REL: begin
        if (!raw_coin) coin_next = COIN_IDLE;
      end
      default: begin
        coin_next     = COIN_IDLE;
        coin_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Autofire
  // ---------------------------------------------------------------------------
  logic [AF_W-1:0] af_cnt;
  logic            af_phase;

  // Autofire modulation. The phase rests at 1 whenever fire is released or
  // autofire is off, so the first output cycle of every press is high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
      btn_fire <= 1'b0;
    end else if (!autofire_en) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
      btn_fire <= raw_fire;
    end else if (raw_fire) begin
      btn_fire <= af_phase;
      if (af_cnt == AF_LAST) begin
        af_cnt   <= '0;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt + AF_ONE;
      end
    end else begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
      btn_fire <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pleiads_input_ctrl.sv
// tb_pleiads_input_ctrl
//
// Directed bench for pleiads_input_ctrl. It uses short coin and autofire
// periods (pulse 8, gap 4, autofire half-period 3). Inputs are driven 1 time
// unit after each rising edge. Outputs are compared at the same point.

module tb_pleiads_input_ctrl;

  logic        clk;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        autofire_en;
  logic        btn_coin;
  logic [1:0]  btn_player_start;
  logic        btn_left;
  logic        btn_right;
  logic        btn_barrier;
  logic        btn_fire;

  logic [6:0]  all_outs;
  logic        tgl;
  int          n_asserts;
  int          n_fail;

  assign all_outs = {btn_coin, btn_player_start, btn_left, btn_right, btn_barrier, btn_fire};

  pleiads_input_ctrl #(
    .COIN_PULSE_CYCLES(8),
    .COIN_GAP_CYCLES  (4),
    .AUTOFIRE_PERIOD  (3)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ps2_key         (ps2_key),
    .joystick_0      (joystick_0),
    .joystick_1      (joystick_1),
    .autofire_en     (autofire_en),
    .btn_coin        (btn_coin),
    .btn_player_start(btn_player_start),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .btn_barrier     (btn_barrier),
    .btn_fire        (btn_fire)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges and settle just past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one PS/2 key event by flipping the toggle bit.
  task automatic applyStimulus(input logic pressed, input logic ext, input logic [7:0] code);
    tgl     = ~tgl;
    ps2_key = {tgl, pressed, ext, code};
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [3:0] af_exp;
    n_asserts   = 0;
    n_fail      = 0;
    tgl         = 1'b0;
    reset_n     = 1'b0;
    ps2_key     = 11'h000;
    joystick_0  = 16'h0000;
    joystick_1  = 16'h0000;
    autofire_en = 1'b0;
    tick(2);

    // A toggle flip while in reset must not become a key press afterwards.
    applyStimulus(1'b1, 1'b0, 8'h29);
    tick(1);
    checkOutput("reset_hold_outs", 16'(all_outs), 16'h0);
    reset_n = 1'b1;
    tick(3);
    checkOutput("reset_release_outs", 16'(all_outs), 16'h0);

    // Fire key: two-edge latency on press and on release.
    applyStimulus(1'b1, 1'b0, 8'h29);
    tick(1);
    checkOutput("fire_key_lat1", 16'(btn_fire), 16'h0);
    tick(1);
    checkOutput("fire_key_on", 16'(btn_fire), 16'h1);
    applyStimulus(1'b0, 1'b0, 8'h29);
    tick(1);
    checkOutput("fire_key_rel_lat1", 16'(btn_fire), 16'h1);
    tick(1);
    checkOutput("fire_key_off", 16'(btn_fire), 16'h0);

    // Right is an X code: both extended and plain forms decode.
    applyStimulus(1'b1, 1'b1, 8'h74);
    tick(2);
    checkOutput("right_ext_on", 16'(btn_right), 16'h1);
    applyStimulus(1'b0, 1'b1, 8'h74);
    tick(2);
    checkOutput("right_ext_off", 16'(btn_right), 16'h0);
    applyStimulus(1'b1, 1'b0, 8'h74);
    tick(2);
    checkOutput("right_plain_on", 16'(btn_right), 16'h1);
    applyStimulus(1'b0, 1'b0, 8'h74);
    tick(2);
    checkOutput("right_plain_off", 16'(btn_right), 16'h0);

    // Fire is an exact code: the extended form is an unknown key.
    applyStimulus(1'b1, 1'b1, 8'h29);
    tick(2);
    checkOutput("fire_ext_ignored", 16'(all_outs), 16'h0);
    applyStimulus(1'b0, 1'b1, 8'h29);
    tick(2);

    // Start keys, each held independently.
    applyStimulus(1'b1, 1'b0, 8'h16);
    tick(2);
    checkOutput("start1_on", 16'(btn_player_start), 16'h1);
    applyStimulus(1'b1, 1'b0, 8'h1E);
    tick(2);
    checkOutput("start_both", 16'(btn_player_start), 16'h3);
    applyStimulus(1'b0, 1'b0, 8'h16);
    tick(2);
    checkOutput("start2_only", 16'(btn_player_start), 16'h2);
    applyStimulus(1'b0, 1'b0, 8'h1E);
    tick(2);
    checkOutput("start_off", 16'(btn_player_start), 16'h0);

    // Second-player barrier key.
    applyStimulus(1'b1, 1'b0, 8'h1B);
    tick(2);
    checkOutput("barrier2_on", 16'(btn_barrier), 16'h1);
    applyStimulus(1'b0, 1'b0, 8'h1B);
    tick(2);
    checkOutput("barrier2_off", 16'(btn_barrier), 16'h0);

    // Simultaneous left and right resolve to neutral.
    joystick_0 = 16'h0001;
    joystick_1 = 16'h0002;
    tick(1);
    checkOutput("socd_neutral", 16'({btn_left, btn_right}), 16'h0);
    joystick_1 = 16'h0000;
    tick(1);
    checkOutput("socd_right_after", 16'({btn_left, btn_right}), 16'h1);
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0002;
    tick(1);
    checkOutput("joy_left_only", 16'({btn_left, btn_right}), 16'h2);
    joystick_1 = 16'h0000;
    tick(1);

    // Coin held 40 cycles: exactly 8 high cycles, then low.
    joystick_0 = 16'h0100;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      checkOutput($sformatf("coin_hold_c%0d", i), 16'(btn_coin), (i <= 8) ? 16'h1 : 16'h0);
    end
    joystick_0 = 16'h0000;
    tick(1);
    checkOutput("coin_release", 16'(btn_coin), 16'h0);

    // Re-press after the gap gives a second full pulse.
    joystick_0 = 16'h0100;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      checkOutput($sformatf("coin_repress_c%0d", i), 16'(btn_coin), (i <= 8) ? 16'h1 : 16'h0);
    end
    joystick_0 = 16'h0000;
    tick(2);

    // Coin held through reset produces nothing until re-pressed.
    joystick_0 = 16'h0100;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      checkOutput($sformatf("coin_thru_reset_c%0d", i), 16'(btn_coin), 16'h0);
    end
    joystick_0 = 16'h0000;
    tick(1);
    // Press for one cycle only. The pulse must still be the full length.
    joystick_0 = 16'h0100;
    tick(1);
    checkOutput("coin_after_reset_c1", 16'(btn_coin), 16'h1);
    joystick_0 = 16'h0000;
    for (int i = 2; i <= 12; i++) begin
      tick(1);
      checkOutput($sformatf("coin_short_c%0d", i), 16'(btn_coin), (i <= 8) ? 16'h1 : 16'h0);
    end
    tick(1);

    // Single-cycle coin key event still gives a full pulse.
    applyStimulus(1'b1, 1'b0, 8'h2E);
    tick(1);
    checkOutput("coin_key_lat1", 16'(btn_coin), 16'h0);
    applyStimulus(1'b0, 1'b0, 8'h2E);
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      checkOutput($sformatf("coin_key_c%0d", i), 16'(btn_coin), (i <= 8) ? 16'h1 : 16'h0);
    end
    tick(1);

    // Autofire: 12 held cycles give 111000111000.
    autofire_en = 1'b1;
    joystick_0  = 16'h0010;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      checkOutput($sformatf("af_pattern_c%0d", i), 16'(btn_fire),
                  ((((i - 1) / 3) % 2) == 0) ? 16'h1 : 16'h0);
    end
    joystick_0 = 16'h0000;
    tick(1);
    checkOutput("af_release", 16'(btn_fire), 16'h0);

    // Switching autofire off and on mid-press takes effect at the next edge.
    joystick_0 = 16'h0010;
    tick(4);
    checkOutput("af_mid_c4", 16'(btn_fire), 16'h0);
    autofire_en = 1'b0;
    tick(1);
    checkOutput("af_off_mid", 16'(btn_fire), 16'h1);
    autofire_en = 1'b1;
    af_exp = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput($sformatf("af_reon_c%0d", i + 1), 16'(btn_fire), 16'(af_exp[i]));
    end
    joystick_0  = 16'h0000;
    autofire_en = 1'b0;
    tick(1);

    // Autofire disabled: fire follows raw input with one-edge latency.
    joystick_1 = 16'h0010;
    tick(1);
    checkOutput("fire_raw_on", 16'(btn_fire), 16'h1);
    joystick_1 = 16'h0000;
    tick(1);
    checkOutput("fire_raw_off", 16'(btn_fire), 16'h0);

    // Reset mid-operation clears the held key and an active coin pulse.
    applyStimulus(1'b1, 1'b1, 8'h14);
    joystick_0 = 16'h0100;
    tick(2);
    checkOutput("pre_reset_busy", 16'({btn_coin, btn_barrier}), 16'h3);
    reset_n = 1'b0;
    tick(1);
    checkOutput("mid_reset_outs", 16'(all_outs), 16'h0);
    joystick_0 = 16'h0000;
    reset_n    = 1'b1;
    tick(2);
    checkOutput("post_reset_outs", 16'(all_outs), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
